// File: rtl/clz_expand.sv
// Multi-cycle inverse of count-leading-zeros: right-shifts a left-normalized word
// by its leading-zero count over five binary-weighted steps (16, 8, 4, 2, 1).
module clz_expand #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] norm,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned K_W      = 3;
  localparam int unsigned LAST_K   = 4;
  localparam int unsigned MAX_CNT  = WIDTH;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             errp_q, errp_d;
  logic [WIDTH-1:0] r_d;
  logic             busy_d, done_d, err_d;
  logic [WIDTH-1:0] shifted;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (k_q == K_W'(LAST_K)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One binary-weighted step; count bit 5 (a full 32) zeroes the word on the first step
  always_comb begin
    shifted = sreg_q;
    case (k_q)
      3'd0:    shifted = cnt_q[5] ? '0 : (cnt_q[4] ? (sreg_q >> 16) : sreg_q);
      3'd1:    shifted = cnt_q[3] ? (sreg_q >> 8) : sreg_q;
      3'd2:    shifted = cnt_q[2] ? (sreg_q >> 4) : sreg_q;
      3'd3:    shifted = cnt_q[1] ? (sreg_q >> 2) : sreg_q;
      3'd4:    shifted = cnt_q[0] ? (sreg_q >> 1) : sreg_q;
      default: shifted = sreg_q;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    errp_d = errp_q;
    r_d    = r;
    busy_d = busy;
    done_d = 1'b0;
    err_d  = err;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d = norm;
          cnt_d  = (count > CNT_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : count;
          errp_d = (count > CNT_W'(MAX_CNT)) ||
                   ((count < CNT_W'(MAX_CNT)) && !norm[WIDTH-1]);
          k_d    = '0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        if (k_q == K_W'(LAST_K)) begin
          r_d    = shifted;
          err_d  = errp_q;
          done_d = 1'b1;
          busy_d = 1'b0;
          k_d    = '0;
        end else begin
          sreg_d = shifted;
          k_d    = k_q + K_W'(1);
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      k_q    <= '0;
      errp_q <= 1'b0;
      r      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      errp_q <= errp_d;
      r      <= r_d;
      busy   <= busy_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: doc/clz_expand.md
Name: clz_expand

Overview:
- Multi-cycle inverse of the CPU's count-leading-zeros unit.
- Takes a left-normalized word and its leading-zero count, and shifts right to restore the original operand.
- Round-trip contract: for any x with n = CLZ(x), feeding norm = x << n and count = n returns x.
- Sits beside the ALU/MDU as a start/busy/done multi-cycle unit. It is used by the divide pre-normalization path and by the self-check path that verifies CLZ results.

Parameters:
- WIDTH, 32, data width; the implementation supports only 32.
- CNT_W, 6, width of the count field; covers 0..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy=0
- norm  in  32  normalized operand; bit 31 set unless count=32
- count  in  6  leading-zero count, legal range 0..32
- r  out  32  restored operand
- busy  out  1  high while a shift is in progress
- done  out  1  single-cycle pulse; r is valid from this cycle onward
- err  out  1  encoding error flag for the last operation; valid with done

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE, r=0, busy=0, done=0, err=0, internal shift register and step counter cleared. Deasserting rst_n mid-operation abandons the operation; no done is produced.
- States:
  - IDLE: waiting for start.
  - SHIFT: five steps, step counter k=0..4.
- IDLE, start=1 at edge E0:
  - Capture norm into the shift register and the clamped count into a count register.
  - Compute err.
  - Set busy=1 and go to SHIFT with k=0.
- Count clamp: count>32 is treated as 32.
- err rule: err=1 when count>32, or when count<32 and norm[31]=0. Otherwise err=0.
- err does not stop the operation; the result is still computed from the clamped count.
- SHIFT, edges E1..E5: at step k, if count-register bit (4-k) is 1, logical right shift by 2^(4-k) (16, 8, 4, 2, 1). Zeros fill from the MSB.
- Count 32: bit 5 forces the shift register to zero at E1. Bits 4..0 are ignored.
- At E5 (k=4):
  - Load r with the final shifted value.
  - Assert done=1 for exactly one cycle and drop busy to 0.
  - Return to IDLE.
- Fixed latency: done is high in the cycle after the 5th edge following the start edge, independent of count.
- r and err hold their values until the next accepted start's completion. r does not change during SHIFT.
- start while busy=1 is ignored, with no queuing.
- start in the same cycle as done=1 is legal because busy is already 0; it is accepted at that edge.
- norm and count are sampled only at the accept edge. Changes during SHIFT have no effect.
- done, busy and err are registered outputs with no combinational path from the inputs.

Test Plan:
- norm=0x80000000, count=0, start pulse -> busy=1 for 5 cycles, then done=1 for one cycle, r=0x80000000, err=0.
- norm=0x80000000, count=31 -> r=0x00000001, err=0. Separately, norm=0xABCD0000, count=16 -> r=0x0000ABCD, err=0.
- norm=0x00000000, count=32 -> r=0, err=0. Separately, norm=0xFFFFFFFF, count=40 -> r=0, err=1 (clamped to 32).
- norm=0x40000000, count=3 -> err=1, r=0x08000000, latency unchanged.
- Accept norm=0xC0000000, count=4, then pulse start with norm=0xFFFFFFFF, count=0 two cycles later -> second start ignored, r=0x0C000000. Then issue a new start in the done cycle -> accepted, its done follows 6 cycles after the first done.
- Start a count=5 operation and pull rst_n low during cycle 3 -> r=0, busy=0, done=0, err=0 immediately. No done after release. The next start completes normally.
- Randomized round-trip: 1000 random x (including 0 and 1), n=CLZ(x), norm=x<<n -> r==x and err=0 every time.
